// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, func3 encodings,
// and helpers for access legality and byte-enable generation.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic access_legal(input logic [2:0] func3,
                                        input logic [1:0] byte_off,
                                        input logic       is_store);
    logic ok;
    case (func3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~byte_off[0];
      F3_W:    ok = (byte_off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~byte_off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] func3,
                                           input logic [1:0] byte_off);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << byte_off;
      2'b01:   be = 4'b0011 << byte_off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and the data memory (slave).
interface load_store_unit_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memBe;
  logic        memGnt;
  logic        memRValid;
  logic [31:0] memRData;

  modport master (
    output memReq, memWe, memAddr, memWData, memBe,
    input  memGnt, memRValid, memRData
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData, memBe,
    output memGnt, memRValid, memRData
  );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word[8*gi +: 8];
  end

  assign sel_byte = lane[byte_off];
  assign sel_half = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (func3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, sel_byte};
      F3_HU:   data = {16'd0, sel_half};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: checks legality, runs one bus transaction per access while
// stalling the pipeline, and returns the aligned load result in the DONE cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  func3M,
  input  logic [31:0] addrM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallMem,
  output logic        accessErr,
  load_store_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0] capture_reg, capture_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;

  logic        access;
  logic        legal;
  logic        timeout;
  logic        stall_c;
  logic        err_c;
  logic [31:0] store_lanes;
  logic [31:0] aligned;

  // Replicate the store datum across every lane; byte enables pick the live ones.
  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_lanes[8*gi +: 8] =
        (func3M[1:0] == 2'b00) ? writeDataM[7:0] :
        (func3M[1:0] == 2'b01) ? writeDataM[8*(gi%2) +: 8] :
                                 writeDataM[8*gi +: 8];
  end

  // addrM/func3M are frozen by the stall, so DONE can still align from them.
  load_align u_load_align (
    .word     (capture_reg),
    .byte_off (addrM[1:0]),
    .func3    (func3M),
    .data     (aligned)
  );

  assign access  = memReadM | memWriteM;
  assign legal   = access_legal(func3M, addrM[1:0], memWriteM);
  assign timeout = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      capture_reg <= '0;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      capture_reg <= capture_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      be_reg      <= be_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    capture_next = capture_reg;
    req_next     = req_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    be_next      = be_reg;
    stall_c      = 1'b0;
    err_c        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          if (legal) begin
            stall_c      = 1'b1;
            state_next   = ST_REQ;
            cnt_next     = '0;
            capture_next = '0;
            req_next     = 1'b1;
            we_next      = memWriteM;
            addr_next    = {addrM[31:2], 2'b00};
            wdata_next   = store_lanes;
            be_next      = access_be(func3M, addrM[1:0]);
          end else begin
            err_c = 1'b1;
          end
        end
      end

      ST_REQ: begin
        stall_c  = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (bus.memGnt) begin
          req_next = 1'b0;
          we_next  = 1'b0;
          if (we_reg) begin
            state_next = ST_DONE;
          end else if (bus.memRValid) begin
            capture_next = bus.memRData;
            state_next   = ST_DONE;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (timeout) begin
          err_c        = 1'b1;
          capture_next = '0;
          req_next     = 1'b0;
          we_next      = 1'b0;
          state_next   = ST_DONE;
        end
      end

      ST_WAIT: begin
        stall_c  = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        // A response arriving in the last allowed cycle still wins over the timeout.
        if (bus.memRValid) begin
          capture_next = bus.memRData;
          state_next   = ST_DONE;
        end else if (timeout) begin
          err_c        = 1'b1;
          capture_next = '0;
          state_next   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign stallMem  = stall_c & rst_n;
  assign accessErr = err_c & rst_n;
  assign readDataM = (state_reg == ST_DONE) ? aligned : '0;

  assign bus.memReq   = req_reg;
  assign bus.memWe    = we_reg;
  assign bus.memAddr  = addr_reg;
  assign bus.memWData = wdata_reg;
  assign bus.memBe    = be_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: byte-level memory reference model,
// expected responses queued at issue, and a negedge monitor comparing DUT events.
module tb_load_store_unit;

  localparam int TMO = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memReadM, memWriteM;
  logic [2:0]  func3M;
  logic [31:0] addrM, writeDataM;
  logic [31:0] readDataM;
  logic        stallMem, accessErr;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .func3M     (func3M),
    .addrM      (addrM),
    .writeDataM (writeDataM),
    .readDataM  (readDataM),
    .stallMem   (stallMem),
    .accessErr  (accessErr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          stalls;   // negative: not checked
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  exp_t     exp_q[$];
  bus_exp_t bus_q[$];

  logic [7:0]  ref_bytes [64];
  logic [31:0] slave_mem [16];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit       req_prev = 1'b0;
  int       stall_cnt = 0;
  exp_t     mon_e;
  bus_exp_t mon_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (bus.memReq && !req_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=%h required=no_request", bus.memAddr);
        end else begin
          mon_b = bus_q.pop_front();
          check("bus_addr", bus.memAddr, mon_b.addr);
          check("bus_we", 32'(bus.memWe), 32'(mon_b.we));
          check("bus_be", 32'(bus.memBe), 32'(mon_b.be));
          if (mon_b.we) check("bus_wdata", bus.memWData, mon_b.wdata);
        end
      end
      req_prev = bus.memReq;
      if (stallMem) stall_cnt++;

      if (accessErr || ((memReadM || memWriteM) && !stallMem)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=err%0d/%h required=none", accessErr, readDataM);
        end else begin
          mon_e = exp_q.pop_front();
          check("evt_is_err", 32'(accessErr), 32'(mon_e.is_err));
          check("evt_rdata", readDataM, mon_e.data);
          if (mon_e.stalls >= 0) begin
            check("evt_stalls", stall_cnt, mon_e.stalls);
            stall_cnt = 0;
          end
          $display("event err=%0d rdata=%h stalls=%0d", accessErr, readDataM, stall_cnt);
        end
      end else begin
        check("rdata_idle", readDataM, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    memReadM  = 1'b0;
    memWriteM = 1'b0;
    bus.memGnt    = 1'b0;
    bus.memRValid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gdly, input int rdly);
    int size, off, rr, ncyc, idx;
    bit legal, tmo;
    logic [31:0] expv, wexp;
    exp_t e;
    bus_exp_t b;

    size  = size_of(f3);
    off   = int'(a - BASE);
    legal = ((f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5))) && (a % size == 0);

    memWriteM  = st;
    memReadM   = !st;
    func3M     = f3;
    addrM      = a;
    writeDataM = wd;
    bus.memGnt    = 1'($urandom);
    bus.memRValid = 1'($urandom);
    bus.memRData  = $urandom;

    if (!legal) begin
      e.is_err = 1'b1; e.data = 32'h0; e.stalls = 0;
      exp_q.push_back(e);
      step();
      idle(0);
      return;
    end

    rr   = st ? gdly + 1 : gdly + 1 + rdly;
    tmo  = (rr > TMO);
    ncyc = tmo ? TMO : rr;

    for (int i = 0; i < 4; i++) wexp[8*i +: 8] = 8'(wd >> (8 * (i % size)));
    b.addr  = a & 32'hFFFF_FFFC;
    b.we    = st;
    b.be    = 4'(((1 << size) - 1) << (a % 4));
    b.wdata = wexp;
    bus_q.push_back(b);

    expv = 32'h0;
    if (!st) begin
      for (int i = 0; i < size; i++) expv = expv | (32'(ref_bytes[off + i]) << (8 * i));
      if (f3[2] == 1'b0 && size < 4 && expv[8*size-1]) expv = expv | (32'hFFFF_FFFF << (8 * size));
    end else if (!tmo) begin
      for (int i = 0; i < size; i++) ref_bytes[off + i] = 8'(wd >> (8 * i));
    end

    if (tmo) begin
      e.is_err = 1'b1; e.data = 32'h0; e.stalls = -1;
      exp_q.push_back(e);
    end
    e.is_err = 1'b0; e.data = tmo ? 32'h0 : expv; e.stalls = 1 + ncyc;
    exp_q.push_back(e);

    for (int c = 1; c <= ncyc; c++) begin
      step();
      bus.memGnt    = (c == gdly + 1) || (c > gdly + 1 && ($urandom % 2 == 1));
      bus.memRValid = !st && (c == rr);
      idx = int'((bus.memAddr - BASE) >> 2) & 15;
      bus.memRData  = bus.memRValid ? slave_mem[idx] : $urandom;
      if (c == gdly + 1 && bus.memWe) begin
        for (int i = 0; i < 4; i++)
          if (bus.memBe[i]) slave_mem[idx][8*i +: 8] = bus.memWData[8*i +: 8];
      end
    end
    step();  // DONE cycle: bus noise must be ignored
    bus.memGnt    = 1'($urandom);
    bus.memRValid = 1'($urandom);
    bus.memRData  = $urandom;
    step();
    idle(0);
    $display("access st=%0d f3=%0d addr=%h wd=%h gdly=%0d rdly=%0d tmo=%0d", st, f3, a, wd, gdly, rdly, tmo);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    int pick, gdly, rdly;

    for (int w = 0; w < 16; w++) begin
      slave_mem[w] = $urandom;
      for (int i = 0; i < 4; i++) ref_bytes[4*w + i] = slave_mem[w][8*i +: 8];
    end

    // Legal store presented during reset must not stall.
    memWriteM = 1'b1; memReadM = 1'b0; func3M = 3'b010;
    addrM = 32'h100; writeDataM = 32'h1234_5678;
    bus.memGnt = 1'b0; bus.memRValid = 1'b0; bus.memRData = 32'h0;
    #22;
    check("rst_stall", 32'(stallMem), 32'h0);
    check("rst_err", 32'(accessErr), 32'h0);
    check("rst_rdata", readDataM, 32'h0);
    check("rst_req", 32'(bus.memReq), 32'h0);
    check("rst_we", 32'(bus.memWe), 32'h0);
    check("rst_addr", bus.memAddr, 32'h0);
    check("rst_wdata", bus.memWData, 32'h0);
    check("rst_be", 32'(bus.memBe), 32'h0);
    idle(0);
    step();
    rst_n = 1'b1;
    idle(2);

    // Directed cases
    do_access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0);
    do_access(1'b1, 3'b010, 32'h100, 32'h80112233, 1, 0);
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 3);
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 3);
    do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0);
    do_access(1'b0, 3'b001, 32'h101, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h108, 32'h0, 9, 0);
    do_access(1'b1, 3'b100, 32'h10C, 32'h55, 0, 0);
    do_access(1'b1, 3'b000, 32'h10D, 32'hA5A5_A5C3, 2, 0);
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 0);

    // Reset while waiting for read data abandons the access silently.
    bus_q.push_back('{addr: 32'h10C, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    memReadM = 1'b1; memWriteM = 1'b0; func3M = 3'b010; addrM = 32'h10C;
    step();
    bus.memGnt = 1'b1;
    step();
    bus.memGnt = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(stallMem), 32'h0);
    check("abort_req", 32'(bus.memReq), 32'h0);
    check("abort_err", 32'(accessErr), 32'h0);
    memReadM = 1'b0;
    step();
    rst_n = 1'b1;
    bus.memRValid = 1'b1; bus.memRData = 32'hFFFF_FFFF;
    step();
    step();
    check("post_abort_req", 32'(bus.memReq), 32'h0);
    check("post_abort_stall", 32'(stallMem), 32'h0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      st   = 1'($urandom);
      pick = $urandom_range(0, 19);
      f3   = (pick < 4) ? 3'd0 : (pick < 8) ? 3'd1 : (pick < 12) ? 3'd2 :
             (pick < 15) ? 3'd4 : (pick < 18) ? 3'd5 : (pick == 18) ? 3'd3 : 3'd7;
      a    = BASE + 32'($urandom_range(0, 63));
      if ($urandom % 4 != 0) a = a & ~32'(size_of(f3) - 1);
      gdly = ($urandom % 8 == 0) ? 9 : $urandom_range(0, 2);
      rdly = $urandom_range(0, 3);
      do_access(st, f3, a, $urandom, gdly, rdly);
      if ($urandom % 3 == 0) idle($urandom_range(1, 2));
    end

    idle(5);
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("bus_q_drained", bus_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
